// File: rtl/mem_wb_stage.sv
`timescale 1ns/1ps
// mem_wb_stage
// ------------------------------------------------------------------------
// MEM/WB pipeline register with a small RUN/HALTED controller.
//
// When the stage is running and MEM presents a valid, unstalled, unflushed
// instruction, that instruction is captured into the WB registers.
// Otherwise a bubble is inserted: the control flags drop to 0 and the data
// registers keep their previous values. A captured HLT moves the stage to
// HALTED, which it leaves only on reset.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   stall, flush          MEM not advancing / discard the MEM entry
//   *_MEM                 instruction, control and data presented by MEM
//   *_WB                  registered write-back outputs
//   RegWrt_Data_WB        write-back mux output (load data or ALU result)
//   hlt                   processor halted
//   retire_cnt            saturating count of retired instructions
//
// Configuration
//   WB_RETIRE_CNT_EN      when defined, retire_cnt is a saturating counter;
//                         when undefined, retire_cnt is tied to 0.
// ------------------------------------------------------------------------
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        Valid_MEM,
    input  logic [15:0] Instr_MEM,
    input  logic        RegWrt_MEM,
    input  logic [3:0]  Rd_MEM,
    input  logic        MemToReg_MEM,
    input  logic [15:0] ALURes_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrt_MEM,
    input  logic [15:0] MemWrt_Data_MEM,
    input  logic [15:0] MemRead_Data_MEM,
    input  logic        Halt_MEM,
    output logic        Valid_WB,
    output logic [15:0] Instr_WB,
    output logic        RegWrt_WB,
    output logic [3:0]  Rd_WB,
    output logic [15:0] RegWrt_Data_WB,
    output logic        MemRead_WB,
    output logic        MemWrt_WB,
    output logic [15:0] MemAddr_WB,
    output logic [15:0] MemWrt_Data_WB,
    output logic [15:0] MemRead_Data_WB,
    output logic        hlt,
    output logic [15:0] retire_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } stateT;

    stateT state;
    stateT nextState;
    logic  capture;
    logic  memToRegWb;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: only a captured HLT leaves RUN; HALTED is absorbing
    always_comb begin
        nextState = state;
        case (state)
            RUN:     if (capture && Halt_MEM) nextState = HALTED;
            HALTED:  nextState = HALTED;
            default: nextState = RUN;
        endcase
    end

    // Output logic: capture is only possible in RUN, hlt is asserted in HALTED.
    // Because the state flips on the same edge that loads the HLT into WB,
    // hlt rises in the cycle the HLT sits in WB.
    always_comb begin
        capture = 1'b0;
        hlt     = 1'b0;
        case (state)
            RUN:     capture = !stall && !flush && Valid_MEM;
            HALTED:  hlt = 1'b1;
            default: ;
        endcase
    end

    // Control flags: loaded on capture, forced to 0 on every bubble.
    // R0 writes are dropped here, and a simultaneous load+store is treated
    // as illegal so neither memory flag propagates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Valid_WB   <= 1'b0;
            RegWrt_WB  <= 1'b0;
            MemRead_WB <= 1'b0;
            MemWrt_WB  <= 1'b0;
        end else if (capture) begin
            Valid_WB   <= 1'b1;
            RegWrt_WB  <= RegWrt_MEM && (Rd_MEM != 4'd0);
            MemRead_WB <= MemRead_MEM && !MemWrt_MEM;
            MemWrt_WB  <= MemWrt_MEM && !MemRead_MEM;
        end else begin
            Valid_WB   <= 1'b0;
            RegWrt_WB  <= 1'b0;
            MemRead_WB <= 1'b0;
            MemWrt_WB  <= 1'b0;
        end
    end

    // Data registers: loaded on capture, held across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Instr_WB        <= 16'h0000;
            Rd_WB           <= 4'd0;
            memToRegWb      <= 1'b0;
            MemAddr_WB      <= 16'h0000;
            MemWrt_Data_WB  <= 16'h0000;
            MemRead_Data_WB <= 16'h0000;
        end else if (capture) begin
            Instr_WB        <= Instr_MEM;
            Rd_WB           <= Rd_MEM;
            memToRegWb      <= MemToReg_MEM;
            MemAddr_WB      <= ALURes_MEM;
            MemWrt_Data_WB  <= MemWrt_Data_MEM;
            MemRead_Data_WB <= MemRead_Data_MEM;
        end
    end

    // Write-back mux, fed only from registered state
    assign RegWrt_Data_WB = memToRegWb ? MemRead_Data_WB : MemAddr_WB;

`ifdef WB_RETIRE_CNT_EN
    logic [15:0] retireCnt;

    // Retired-instruction counter; sticks at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retireCnt <= 16'h0000;
        end else if (capture && (retireCnt != 16'hFFFF)) begin
            retireCnt <= retireCnt + 16'd1;
        end
    end

    assign retire_cnt = retireCnt;
`else
    assign retire_cnt = 16'h0000;
`endif

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 No parameters; data width fixed at 16 bits and register index width fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 stall  input  1  MEM stage not advancing this cycle.
REQ-005 flush  input  1  discard the entry presented by MEM.
REQ-006 Valid_MEM  input  1  MEM holds a real instruction.
REQ-007 Instr_MEM  input  16  instruction word in MEM.
REQ-008 RegWrt_MEM  input  1  instruction writes the register file.
REQ-009 Rd_MEM  input  4  destination register.
REQ-010 MemToReg_MEM  input  1  write-back source: 1 = memory read data, 0 = ALU result.
REQ-011 ALURes_MEM  input  16  ALU result; also the memory address.
REQ-012 MemRead_MEM  input  1  load in MEM.
REQ-013 MemWrt_MEM  input  1  store in MEM.
REQ-014 MemWrt_Data_MEM  input  16  store data.
REQ-015 MemRead_Data_MEM  input  16  data returned by data memory.
REQ-016 Halt_MEM  input  1  HLT instruction in MEM.
REQ-017 Valid_WB  output  1  WB holds a retired instruction.
REQ-018 Instr_WB  output  16  registered instruction.
REQ-019 RegWrt_WB  output  1  register-file write enable.
REQ-020 Rd_WB  output  4  register-file write index.
REQ-021 RegWrt_Data_WB  output  16  register-file write data.
REQ-022 MemRead_WB / MemWrt_WB  output  1 each  registered load and store flags.
REQ-023 MemAddr_WB / MemWrt_Data_WB / MemRead_Data_WB  output  16 each  registered address, store data and load data.
REQ-024 hlt  output  1  processor halted.
REQ-025 retire_cnt  output  16  retired-instruction count.

Function
REQ-026 Capture rule: capture occurs when the FSM is in RUN, stall=0, flush=0 and Valid_MEM=1. On capture, every *_WB register SHALL load its *_MEM counterpart on the next edge, and Valid_WB SHALL be 1; latency is exactly 1 cycle.
REQ-027 Bubble rule: otherwise (stall, flush, both, or Valid_MEM=0), Valid_WB, RegWrt_WB, MemRead_WB and MemWrt_WB SHALL be 0; data registers SHALL hold their previous value.
REQ-028 Write-back mux: RegWrt_Data_WB SHALL equal MemRead_Data_WB when the registered MemToReg bit is 1, else MemAddr_WB. The mux is combinational from registered state only.
REQ-029 R0 suppression: RegWrt_WB SHALL be 0 whenever Rd_WB=0, even if RegWrt_MEM was 1.
REQ-030 Store/load exclusion: if MemRead_MEM=MemWrt_MEM=1 on capture, both *_WB flags SHALL be 0.
REQ-031 FSM states are RUN and HALTED. RUN goes to HALTED on a capture with Halt_MEM=1, and hlt SHALL be 1 in the same cycle that the HLT is in WB.
REQ-032 HALTED is absorbing until reset. In HALTED, hlt=1, no capture occurs, and Valid_WB and all control flags SHALL be 0 from the cycle after the halt.
REQ-033 Halt_MEM with stall or flush SHALL NOT halt; it is retried when MEM next presents it.
REQ-034 retire_cnt SHALL increment by 1 on each capture, including the HLT capture. It SHALL saturate at 0xFFFF, not wrap.

Reset
REQ-035 While rst_n=0, all outputs and registers SHALL be 0, the FSM SHALL be in RUN, and retire_cnt SHALL be 0, independent of clk.
REQ-036 Reset asserted mid-operation, including in HALTED, SHALL take effect immediately. The first capture SHALL occur on the first edge with rst_n=1.

Configuration
REQ-037 With WB_RETIRE_CNT_EN defined, retire_cnt behaves per REQ-034.
REQ-038 Without WB_RETIRE_CNT_EN, retire_cnt SHALL be constant 0 and no counter flops are synthesized; all other behaviour is unchanged.

Verification
REQ-039 Reset, then capture ADD with Rd=3, ALURes=0x1234, MemToReg=0 -> next cycle RegWrt_WB=1, Rd_WB=3, RegWrt_Data_WB=0x1234, Valid_WB=1.
REQ-040 Load with ALURes=0x0040, MemRead_Data=0xBEEF, MemToReg=1, Rd=5 -> MemRead_WB=1, MemAddr_WB=0x0040, RegWrt_Data_WB=0xBEEF; a store presented with stall=1 -> MemWrt_WB=0 that cycle.
REQ-041 Write to Rd=0 with RegWrt_MEM=1 -> RegWrt_WB=0; flush=1 on a valid ADD -> Valid_WB=0 and retire_cnt unchanged.
REQ-042 HLT with stall=1, then stall=0 -> hlt=0 in the first cycle, hlt=1 one cycle after release; later valid inputs are ignored and hlt stays 1.
REQ-043 Preload the counter to 0xFFFE, then 3 captures -> retire_cnt=0xFFFF. Assert rst_n=0 mid-clock -> all outputs 0 immediately. Build without WB_RETIRE_CNT_EN -> retire_cnt=0 throughout.
